// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_defs : shared definitions for the two-master system bus arbiter.
//   - arb_state_t : arbiter FSM state encodings (IDLE/BUSY/RESP)
//   - OWN_*       : encodings of the 'owner' output
//   - DEF_TIMEOUT : default watchdog limit (used only with ARB_TIMEOUT_EN)
//   - owner_code  : maps a master index (0/1) to its owner encoding
// -----------------------------------------------------------------------------
package bus_arb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int DEF_TIMEOUT = 255;

    function automatic logic [1:0] owner_code(input logic id);
        return id ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arb_rr : combinational round-robin pick between two bus masters.
// Ports:
//   m0_req, m1_req : request lines of master 0 / master 1
//   last           : index of the master granted most recently
//   grant_valid    : at least one master is requesting
//   grant_id       : index of the winning master (meaningful with grant_valid)
// -----------------------------------------------------------------------------
module bus_arb_rr (
    input  logic m0_req,
    input  logic m1_req,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = m0_req | m1_req;
    // On a tie the master that did not win last time goes next.
    assign grant_id    = (m0_req & m1_req) ? ~last : m1_req;

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter : two-master arbiter for the single memory-mapped system bus.
// Master 0 is the CPU data port, master 1 the bootloader / DMA master. The
// winning request is registered onto the slave side, held until the slave
// acks, and the response is returned to the owning master for one cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : watchdog ends a transaction after TIMEOUT BUSY cycles without
//               s_ack; the owner sees ack=1, err=1, rdata=0.
//   undefined : BUSY waits for s_ack indefinitely, m*_err tied 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   m{0,1}_req/we/addr/wdata  master requests (req held until ack)
//   m{0,1}_ack/err/rdata      master responses (one-cycle pulse)
//   s_stb/we/addr/wdata       registered slave-side request
//   s_rdata, s_ack            slave response
//   owner                     00 idle, 01 m0, 10 m1
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_defs::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic [1:0]  owner
);

    arb_state_t  r_state, w_state_nx;
    logic [1:0]  r_owner, w_owner_nx;
    logic        r_last,  w_last_nx;
    logic        r_stb,   w_stb_nx;
    logic        r_we,    w_we_nx;
    logic [31:0] r_addr,  w_addr_nx;
    logic [31:0] r_wdata, w_wdata_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic        r_err,   w_err_nx;
    logic        w_grant_valid;
    logic        w_grant_id;
    logic        w_m0_sel;
    logic        w_m1_sel;

`ifdef ARB_TIMEOUT_EN
    // Count value at which the current BUSY cycle is the TIMEOUT-th one.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  r_cnt, w_cnt_nx;
`else
    logic [7:0]  w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
`endif

    bus_arb_rr u_rr (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_stb_nx   = r_stb;
        w_we_nx    = r_we;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_rdata_nx = r_rdata;
        w_err_nx   = r_err;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nx   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_we_nx    = w_grant_id ? m1_we    : m0_we;
                    w_addr_nx  = w_grant_id ? m1_addr  : m0_addr;
                    w_wdata_nx = w_grant_id ? m1_wdata : m0_wdata;
                    w_stb_nx   = 1'b1;
                    w_owner_nx = owner_code(w_grant_id);
                    w_last_nx  = w_grant_id;
                    w_err_nx   = 1'b0;
                    w_state_nx = BUSY;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nx   = 8'd0;
`endif
                end
            end
            BUSY: begin
                // s_stb is always high here, so s_ack is only honoured while strobed.
                if (s_ack) begin
                    w_rdata_nx = s_rdata;
                    w_stb_nx   = 1'b0;
                    w_err_nx   = 1'b0;
                    w_state_nx = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                // A late s_ack on the expiry edge still wins (checked above).
                else if (r_cnt == TO_LAST) begin
                    w_rdata_nx = 32'd0;
                    w_stb_nx   = 1'b0;
                    w_err_nx   = 1'b1;
                    w_state_nx = RESP;
                end else begin
                    w_cnt_nx   = r_cnt + 8'd1;
                end
`endif
            end
            RESP: begin
                w_rdata_nx = 32'd0;
                w_err_nx   = 1'b0;
                w_owner_nx = OWN_NONE;
                w_state_nx = IDLE;
            end
            default: begin
                w_stb_nx   = 1'b0;
                w_owner_nx = OWN_NONE;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
            r_last  <= 1'b1;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_stb   <= w_stb_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_rdata <= w_rdata_nx;
            r_err   <= w_err_nx;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nx;
`endif
        end
    end

    // Responses are steered only to the owner during RESP; the other master sees 0.
    assign w_m0_sel = (r_state == RESP) && (r_owner == OWN_M0);
    assign w_m1_sel = (r_state == RESP) && (r_owner == OWN_M1);

    assign m0_ack   = w_m0_sel;
    assign m1_ack   = w_m1_sel;
    assign m0_rdata = w_m0_sel ? r_rdata : 32'd0;
    assign m1_rdata = w_m1_sel ? r_rdata : 32'd0;
`ifdef ARB_TIMEOUT_EN
    assign m0_err   = w_m0_sel & r_err;
    assign m1_err   = w_m1_sel & r_err;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

    assign s_stb    = r_stb;
    assign s_we     = r_we;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign owner    = r_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter : self-checking bench for bus_arbiter. The bench plays the
// slave, predicts each grant from the round-robin rule and checks every
// transaction at the master and slave ports.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_stb, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  owner;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit mdl_last;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    // Round-robin rule: a lone requester wins; on a tie the master that did not win last goes.
    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_stb"},   {31'd0, s_stb}, 32'd0);
        chk({tag, "_owner"}, {30'd0, owner}, 32'd0);
        chk({tag, "_acks"},  {30'd0, m1_ack, m0_ack}, 32'd0);
        chk({tag, "_errs"},  {30'd0, m1_err, m0_err}, 32'd0);
    endtask

    // Called mid-cycle with the DUT idle and requests driven; returns at a negedge, idle.
    task automatic serve(input int delay, input logic [31:0] rd, input bit drop,
                         input bit keep, output bit win, output int gcyc);
        bit          tmo;
        int          busy;
        logic [31:0] ea, ed, er;
        logic        ew;
        logic [1:0]  eo;
        win      = pick(m0_req, m1_req, mdl_last);
        mdl_last = win;
        ea  = win ? m1_addr  : m0_addr;
        ed  = win ? m1_wdata : m0_wdata;
        ew  = win ? m1_we    : m0_we;
        eo  = win ? 2'b10 : 2'b01;
        tmo = TO_EN && (delay >= TO);
        busy = tmo ? TO : delay + 1;
        er  = tmo ? 32'd0 : rd;
        @(posedge clk); #1;
        gcyc = cyc;
        // Masters change their buses after the grant; the slave side must not follow.
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        m0_we = 1'($urandom); m1_we = 1'($urandom);
        if (drop) begin
            if (win) m1_req = 1'b0; else m0_req = 1'b0;
        end
        @(negedge clk);
        chk("grant_stb",   {31'd0, s_stb}, 32'd1);
        chk("grant_owner", {30'd0, owner}, {30'd0, eo});
        chk("grant_addr",  s_addr, ea);
        chk("grant_wdata", s_wdata, ed);
        chk("grant_we",    {31'd0, s_we}, {31'd0, ew});
        for (int k = 1; k < busy; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_stb",   {31'd0, s_stb}, 32'd1);
            chk("busy_addr",  s_addr, ea);
            chk("busy_wdata", s_wdata, ed);
            chk("busy_acks",  {30'd0, m1_ack, m0_ack}, 32'd0);
        end
        if (!tmo) begin
            s_ack   = 1'b1;
            s_rdata = rd;
        end
        @(posedge clk); #1;
        s_ack   = 1'b0;
        s_rdata = $urandom;
        @(negedge clk);
        chk("resp_stb",   {31'd0, s_stb}, 32'd0);
        chk("resp_owner", {30'd0, owner}, {30'd0, eo});
        chk("resp_ack",   {30'd0, m1_ack, m0_ack}, {30'd0, eo});
        chk("resp_err",   {30'd0, m1_err, m0_err}, tmo ? {30'd0, eo} : 32'd0);
        chk("resp_rdata_own",   win ? m1_rdata : m0_rdata, er);
        chk("resp_rdata_other", win ? m0_rdata : m1_rdata, 32'd0);
        if (!keep) begin
            if (win) m1_req = 1'b0; else m0_req = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("post_resp");
    endtask

    bit w;
    int g, prev_g;

    initial begin
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_s_we",    {31'd0, s_we}, 32'd0);
        chk("reset_s_addr",  s_addr, 32'd0);
        chk("reset_s_wdata", s_wdata, 32'd0);
        chk("reset_rdata",   m0_rdata | m1_rdata, 32'd0);
        rst = 1'b1;
        mdl_last = 1'b1;
        @(negedge clk);

        // Both masters requesting continuously from reset: m0, m1, m0, m1.
        m0_req = 1; m1_req = 1;
        m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000;
        prev_g = -100;
        for (int i = 0; i < 4; i++) begin
            serve(0, $urandom, 1'b0, 1'b1, w, g);
            chk("alt_winner", {31'd0, w}, 32'(i % 2));
            if (i > 0) chk("alt_spacing_ge3", {31'd0, 1'(g - prev_g >= 3)}, 32'd1);
            prev_g = g;
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        // m0 single-cycle read.
        m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0040;
        serve(0, 32'hDEAD_BEEF, 1'b0, 1'b0, w, g);
        chk("t1_winner", {31'd0, w}, 32'd0);

        // m1 write, slave acks after 5 wait cycles.
        m1_req = 1; m1_we = 1; m1_addr = 32'hF020_0000; m1_wdata = 32'h0000_00A5;
        serve(5, $urandom, 1'b0, 1'b0, w, g);
        chk("t3_winner", {31'd0, w}, 32'd1);

        // m0 withdraws one cycle into BUSY; m1 waits behind it.
        m0_req = 1; m1_req = 1; m0_addr = 32'h0000_1234; m1_addr = 32'h0000_5678;
        serve(3, 32'h1111_2222, 1'b1, 1'b0, w, g);
        chk("t4_winner", {31'd0, w}, 32'd0);
        serve(0, 32'h3333_4444, 1'b0, 1'b0, w, g);
        chk("t4_next_winner", {31'd0, w}, 32'd1);

        // Reset in the middle of BUSY.
        m1_req = 1; m1_addr = 32'h0BAD_0000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_busy_stb", {31'd0, s_stb}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b0; m1_req = 0;
        #1;
        chk("t5_async_stb",   {31'd0, s_stb}, 32'd0);
        chk("t5_async_owner", {30'd0, owner}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_idle("t5_after_reset");
        end
        mdl_last = 1'b1;
        m0_req = 1; m1_req = 1;
        serve(0, $urandom, 1'b0, 1'b0, w, g);
        chk("t5_m0_priority", {31'd0, w}, 32'd0);
        m1_req = 0;

        // Hung slave: watchdog build times out, default build stays strobed until ack.
        m0_req = 1; m0_addr = 32'hE000_0000;
        serve(20, 32'h5555_AAAA, 1'b0, 1'b0, w, g);
        // Ack on the cycle the watchdog would expire completes normally.
        m1_req = 1; m1_addr = 32'hE000_0004;
        serve(TO - 1, 32'h7777_8888, 1'b0, 1'b0, w, g);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            m0_req = 1'($urandom); m1_req = 1'($urandom);
            m0_we  = 1'($urandom); m1_we  = 1'($urandom);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            if (!m0_req && !m1_req) begin
                s_ack = 1'b1; s_rdata = $urandom;
                @(posedge clk); #1;
                s_ack = 1'b0;
                @(negedge clk);
                check_idle("rnd_idle");
            end else begin
                serve(int'($urandom_range(0, 6)), $urandom, 1'($urandom), 1'b0, w, g);
            end
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the single memory-mapped system bus (ROM, SRAM, UART, switches, LEDs, GPIO, VGA, PLPID, timer, interrupt controller, PMC, sseg, xbee/motor UARTs).
- Master 0 is the CPU data port. Master 1 is the secondary master (UART bootloader / DMA).
- Registers the winning request onto the slave side, where it feeds the address decoder. Holds the grant until the slave acks, then returns the response to the owning master.
- Round-robin fairness. Optional watchdog terminates hung slaves.

Parameters:
- TIMEOUT, 255, number of cycles s_stb may stay high without s_ack before a bus error (used only with ARB_TIMEOUT_EN); width of the counter is 8 bits, legal 1..255

Ports:
- clk      in   1   system clock, all logic rising-edge
- rst      in   1   reset, asynchronous, active-low
- m0_req   in   1   master 0 request; held high until m0_ack
- m0_we    in   1   master 0 write enable
- m0_addr  in   32  master 0 word-aligned address
- m0_wdata in   32  master 0 write data
- m0_ack   out  1   master 0 transaction done, 1-cycle pulse
- m0_err   out  1   master 0 bus error, coincident with m0_ack
- m0_rdata out  32  master 0 read data, valid while m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical for master 1
- s_stb    out  1   slave strobe, high for the whole transaction
- s_we     out  1   slave write enable
- s_addr   out  32  slave address, to the decoder
- s_wdata  out  32  slave write data
- s_rdata  in   32  slave read data, valid with s_ack
- s_ack    in   1   slave done; sampled only while s_stb=1
- owner    out  2   2'b00 idle, 2'b01 m0, 2'b10 m1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, last=1 (so m0 wins first tie).
  - s_stb, s_we, s_addr, s_wdata, all m*_ack, m*_err and m*_rdata = 0.
  - Reset mid-transaction drops s_stb immediately. The in-flight transfer is abandoned and no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, pick a winner: a single requester wins; if both request, the master != last wins.
  - Latch the winner's we/addr/wdata into s_*, set s_stb=1, set owner, set last=winner, go to BUSY.
  - Decision at edge N; s_stb is high from N+1.
- BUSY:
  - Hold s_* stable.
  - On s_ack=1, capture s_rdata, drop s_stb, go to RESP.
- RESP:
  - Assert the owner's m_ack (and m_err if flagged) for exactly one cycle, with m_rdata = captured data.
  - Non-owner outputs stay 0.
  - Next edge: clear ack/err/rdata, owner=0, go to IDLE.
- Latency:
  - Single-cycle slave (s_ack on first s_stb cycle): req sampled at N, s_stb N+1, ack at N+2.
  - Minimum spacing between back-to-back grants is 3 cycles (IDLE/BUSY/RESP).
- Write transactions also return ack; rdata is then don't-care but is still driven with the captured s_rdata.
- Request withdrawal:
  - A master dropping req during BUSY does not abort; the transaction completes and ack is still pulsed.
  - Req is re-sampled only in IDLE.
- Starvation bound: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- s_ack while s_stb=0 is ignored.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When it reaches TIMEOUT, drop s_stb, set err, force captured rdata=0, go to RESP. The owner then sees ack=1 with err=1.
  - s_ack on the same edge the count reaches TIMEOUT wins: normal completion, err=0.
- ARB_TIMEOUT_EN undefined: no counter, m*_err tied 0, BUSY waits for s_ack indefinitely.

Decomposition:
- Shared package/header bus_arb_defs: state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner codes, default TIMEOUT.
- One sub-module, bus_arb_rr: combinational round-robin pick from {m1_req, m0_req, last}. Outputs grant_valid and grant_id.

Test Plan:
- m0 read 0x10000040, slave acks on first strobe cycle with 0xDEADBEEF -> s_stb high 1 cycle at addr 0x10000040; m0_ack 1 cycle later with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m0 and m1 both request from reset -> grants m0, m1, m0, m1; owner sequence 01, 10, 01, 10; every grant separated by ≥3 cycles.
- m1 write 0xf0200000 data 0x000000A5, slave delays ack 5 cycles -> s_* stable for all 6 BUSY cycles; m1_ack follows, m1_err=0.
- m0 drops req one cycle into BUSY, slave acks 3 cycles later -> m0_ack still pulsed; no new grant until after RESP.
- rst pulled low during BUSY -> s_stb=0 within the same cycle, owner=0, no ack on release; next request is served normally with m0 priority.
- ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> s_stb drops after 4 BUSY cycles; owner sees ack=1, err=1, rdata=0. Without the macro, s_stb stays high.
